// File: rtl/button_debounce_pkg.sv
// Shared types and field layout for the pushbutton debounce/capture block.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } key_state_t;

  localparam int unsigned MAX_KEYS    = 4;
  localparam int unsigned PRESS_CNT_W = 4;

  localparam int unsigned LEVEL_LSB = 0;
  localparam int unsigned LONG_LSB  = 8;
  localparam int unsigned CNT_LSB   = 16;

  // Counter width for a window of n cycles, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Single-key synchroniser, debounce FSM, press counter and long-press hold counter.
// Long-press logic is present only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce_fsm
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_n,
  output logic                   stable,
  output logic                   press_pulse,
  output logic [PRESS_CNT_W-1:0] press_cnt,
  output logic                   long_flag
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_PRESS_CYCLES < 2) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must be at least 2");
  end

  logic             sync1, sync2, s;
  key_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             commit_press, commit_release;
  logic             stable_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // State register; outputs are registered alongside so they change with the commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RELEASED;
      cnt         <= '0;
      stable      <= 1'b0;
      press_pulse <= 1'b0;
      press_cnt   <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      stable      <= stable_next;
      press_pulse <= commit_press;
      if (commit_press) press_cnt <= press_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    commit_press   = 1'b0;
    commit_release = 1'b0;
    unique case (state)
      RELEASED: begin
        if (s) begin
          state_next = WAIT_PRESS;
          cnt_next   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!s) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = PRESSED;
          cnt_next     = '0;
          commit_press = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = WAIT_RELEASE;
          cnt_next   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next     = RELEASED;
          cnt_next       = '0;
          commit_release = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    stable_next = (state_next == PRESSED) || (state_next == WAIT_RELEASE);
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              long_next;

  // Hold time accrues only while steadily pressed; the flag survives a release
  // bounce and drops only when the release is committed.
  always_comb begin
    hold_next = hold_cnt;
    long_next = long_flag;
    if (commit_press) begin
      hold_next = '0;
    end else if (state == PRESSED) begin
      if (hold_cnt == HOLD_LAST) long_next = 1'b1;
      else                       hold_next = hold_cnt + 1'b1;
    end
    if (commit_release) long_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= '0;
      long_flag <= 1'b0;
    end else begin
      hold_cnt  <= hold_next;
      long_flag <= long_next;
    end
  end
`else
  assign long_flag = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_capture.sv
// Debounces up to four active-low pushbuttons and packs levels, long-press flags
// and wrapping press counters into the 32-bit button export word.
// Optional long-press flags: define BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce_capture
  import button_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [31:0]         button_export,
  output logic [NUM_KEYS-1:0] press_pulse
);

  if (NUM_KEYS < 1 || NUM_KEYS > MAX_KEYS) begin : g_bad_keys
    $error("NUM_KEYS must be in 1..4");
  end

  logic [NUM_KEYS-1:0]    stable;
  logic [NUM_KEYS-1:0]    long_flag;
  logic [PRESS_CNT_W-1:0] press_cnt [NUM_KEYS];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_key (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n[i]),
      .stable     (stable[i]),
      .press_pulse(press_pulse[i]),
      .press_cnt  (press_cnt[i]),
      .long_flag  (long_flag[i])
    );
  end

  // Pure wiring of per-key registers; unused and reserved fields read zero.
  always_comb begin
    button_export = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      button_export[LEVEL_LSB + i]                           = stable[i];
      button_export[LONG_LSB + i]                            = long_flag[i];
      button_export[CNT_LSB + PRESS_CNT_W*i +: PRESS_CNT_W] = press_cnt[i];
    end
  end

endmodule

// File: tb/tb_button_debounce_capture.sv
// Self-checking bench for button_debounce_capture: directed scenarios plus random
// key activity, all compared against a run-length reference model.
module tb_button_debounce_capture;

  localparam int NK = 4;
  localparam int D  = 8;
  localparam int L  = 32;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [31:0]   button_export;
  logic [NK-1:0] press_pulse;

  int tests = 0;
  int fails = 0;

  button_debounce_capture #(
    .NUM_KEYS         (NK),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .button_export(button_export),
    .press_pulse  (press_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: key samples reach the debouncer two edges late; a level is
  // committed once D+1 consecutive samples disagree with the committed level.
  logic [NK-1:0] dly1, dly2;
  bit            lvl     [NK];
  int            run     [NK];
  int            pcount  [NK];
  int            hold    [NK];
  bit            lflag   [NK];
  bit            pulse_m [NK];
  int            seen    [NK];

  function automatic void model_reset();
    dly1 = '1;
    dly2 = '1;
    for (int i = 0; i < NK; i++) begin
      lvl[i] = 0; run[i] = 0; pcount[i] = 0; hold[i] = 0; lflag[i] = 0; pulse_m[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    logic [NK-1:0] smp;
    bit            steady;
    smp  = ~dly2;
    dly2 = dly1;
    dly1 = key_n;
    for (int i = 0; i < NK; i++) begin
      pulse_m[i] = 0;
      steady = lvl[i] && (run[i] == 0);
      if (LONG_ON && steady) begin
        if (hold[i] == L - 1) lflag[i] = 1;
        else                  hold[i]++;
      end
      if (smp[i] != lvl[i]) begin
        run[i]++;
        if (run[i] == D + 1) begin
          lvl[i] = smp[i];
          run[i] = 0;
          if (lvl[i]) begin
            pcount[i]  = (pcount[i] + 1) % 16;
            pulse_m[i] = 1;
            hold[i]    = 0;
          end else begin
            lflag[i] = 0;
          end
        end
      end else begin
        run[i] = 0;
      end
    end
  endfunction

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < NK; i++) begin
      w[i]              = lvl[i];
      w[8 + i]          = lflag[i];
      w[16 + 4*i +: 4]  = 4'(pcount[i]);
    end
    return w;
  endfunction

  function automatic logic [31:0] model_pulse();
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < NK; i++) p[i] = pulse_m[i];
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("export", button_export, model_word());
    check("pulse", 32'(press_pulse), model_pulse());
    for (int i = 0; i < NK; i++) if (press_pulse[i]) seen[i]++;
  endtask

  // Steps until export bit idx equals val; lat counts edges from the input drive.
  task automatic wait_bit(input int idx, input logic val, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (button_export[idx] !== val && lat < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, t0, t3;
    for (int i = 0; i < NK; i++) seen[i] = 0;
    key_n = '1;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_export", button_export, 32'h0);
    check("reset_pulse", 32'(press_pulse), 32'h0);
    reset = 1'b0;
    repeat (3) step();

    // Clean press of key0: 2 sync + D cycles after the first sampling edge.
    base = seen[0];
    key_n[0] = 1'b0;
    wait_bit(0, 1'b1, lat);
    check("key0_latency", 32'(lat - 1), 32'(2 + D));
    check("key0_count", 32'(button_export[19:16]), 32'd1);
    repeat (4) step();
    check("key0_pulses", 32'(seen[0] - base), 32'd1);
    key_n[0] = 1'b1;
    wait_bit(0, 1'b0, lat);
    check("key0_release_latency", 32'(lat - 1), 32'(2 + D));
    check("key0_count_kept", 32'(button_export[19:16]), 32'd1);

    // Bounce on key1, then a held press.
    base = seen[1];
    for (int b = 0; b < 3; b++) begin
      key_n[1] = 1'b0; repeat (3) step();
      key_n[1] = 1'b1; repeat (3) step();
    end
    check("bounce_no_pulse", 32'(seen[1] - base), 32'd0);
    check("bounce_no_level", 32'(button_export[1]), 32'd0);
    key_n[1] = 1'b0;
    wait_bit(1, 1'b1, lat);
    check("bounce_latency", 32'(lat - 1), 32'(2 + D));
    check("bounce_count", 32'(button_export[23:20]), 32'd1);
    key_n[1] = 1'b1;
    repeat (14) step();

    // 17 presses of key2 wrap its counter to 1.
    base = seen[2];
    for (int n = 0; n < 17; n++) begin
      key_n[2] = 1'b0; repeat (14) step();
      key_n[2] = 1'b1; repeat (14) step();
    end
    check("key2_pulses", 32'(seen[2] - base), 32'd17);
    check("key2_wrap_count", 32'(button_export[27:24]), 32'd1);

    // Keys 0 and 3 together.
    t0 = -1; t3 = -1;
    key_n[0] = 1'b0; key_n[3] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (press_pulse[0] && t0 < 0) t0 = c;
      if (press_pulse[3] && t3 < 0) t3 = c;
    end
    check("dual_pulse_same_cycle", 32'(t0), 32'(t3));
    check("dual_pulse_time", 32'(t0), 32'(2 + D));
    check("dual_levels", 32'(button_export[3:0]), 32'b1001);
    check("dual_counts", {button_export[31:28], button_export[19:16]}, {4'd1, 4'd2});
    key_n[0] = 1'b1; key_n[3] = 1'b1;
    repeat (14) step();

    // Reset in the middle of WAIT_PRESS with key0 held low.
    key_n[0] = 1'b0;
    repeat (6) step();
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_export", button_export, 32'h0);
    check("async_reset_pulse", 32'(press_pulse), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = seen[0];
    wait_bit(0, 1'b1, lat);
    check("post_reset_latency", 32'(lat - 1), 32'(2 + D));
    check("post_reset_word", button_export, 32'h0001_0001);

    // Long press on key0: flag 32 cycles after the commit when enabled.
    repeat (31) step();
    check("long_not_yet", 32'(button_export[8]), 32'd0);
    step();
    check("long_set", 32'(button_export[8]), 32'(LONG_ON));
    repeat (8) step();
    check("long_held", 32'(button_export[8]), 32'(LONG_ON));
    check("post_reset_pulses", 32'(seen[0] - base), 32'd1);
    key_n[0] = 1'b1;
    repeat (6) step();
    check("long_kept_in_release_window", 32'(button_export[8]), 32'(LONG_ON));
    wait_bit(0, 1'b0, lat);
    check("long_cleared", 32'(button_export[11:8]), 32'd0);

    // Random activity on all keys, checked against the model every cycle.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 5) == 0) key_n[i] = ~key_n[i];
      step();
    end
    key_n = '1;
    repeat (14) step();
    check("final_levels", 32'(button_export[3:0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
